// File: rtl/max6675_spi_reader.sv
// SPI master for the MAX6675: periodic or triggered 16-bit frame read, yields temperature (D14..D3) and open flag (D2).
// Optional build macro MAX6675_FRAME_CHECK_EN rejects frames with D15 or D1 set and raises frame_err.
module max6675_spi_reader #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 12500000,
  parameter int CS_SETUP      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic        miso,
  output logic        cs,
  output logic        sclk,
  output logic [11:0] data,
  output logic        open_tc,
  output logic        drdy,
  output logic        busy,
  output logic        frame_err
);

  localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int TW      = $clog2(SAMPLE_PERIOD);

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   shift;
  logic          frame_bad;
  logic          unused_bits;

`ifdef MAX6675_FRAME_CHECK_EN
  // D15 is a dummy zero and D1 is always zero; either set means SO is floating or stuck.
  assign frame_bad = shift[15] | shift[1];
`else
  assign frame_bad = 1'b0;
`endif

  assign unused_bits = ^{shift[15], shift[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      cs        <= 1'b1;
      sclk      <= 1'b0;
      data      <= '0;
      open_tc   <= 1'b0;
      drdy      <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      timer <= (timer == TIMER_LAST) ? '0 : timer + 1'b1;
      drdy  <= 1'b0;

      case (state)
        IDLE: begin
          if (timer == TIMER_LAST || trig) begin
            state <= SETUP;
            cs    <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end

        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state   <= SHIFT;
            cnt     <= '0;
            bit_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt  <= '0;
            sclk <= ~sclk;
            // Sample at the end of the high phase; the slave changes SO on the falling edge.
            if (sclk) begin
              shift   <= {shift[14:0], miso};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd15) begin
                state <= HOLD;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          if (cnt == SETUP_LAST) begin
            cs    <= 1'b1;
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          drdy  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (frame_bad) begin
            frame_err <= 1'b1;
          end else begin
            frame_err <= 1'b0;
            data      <= shift[14:3];
            open_tc   <= shift[2];
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max6675_spi_reader.sv
// Bench for max6675_spi_reader: MAX6675 slave model, timing monitor, table vectors and random frames.
module tb_max6675_spi_reader;

  localparam int D   = 2;
  localparam int SP  = 200;
  localparam int CSU = 2;
  localparam int FRAME_LEN = 2*CSU + 32*D + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic        miso;
  logic        cs, sclk, open_tc, drdy, busy, frame_err;
  logic [11:0] data;

  max6675_spi_reader #(.CLK_DIV(D), .SAMPLE_PERIOD(SP), .CS_SETUP(CSU)) dut (
    .clk(clk), .rst(rst), .trig(trig), .miso(miso),
    .cs(cs), .sclk(sclk), .data(data), .open_tc(open_tc),
    .drdy(drdy), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Slave: D15 appears on cs fall, next bit after each sclk fall.
  logic [15:0] frame = 16'h0;
  int bit_idx = -1;
  always @(negedge cs) bit_idx = 15;
  always @(negedge sclk) if (!cs) bit_idx = bit_idx - 1;
  assign miso = (!cs && bit_idx >= 0) ? frame[bit_idx[3:0]] : 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor, sampled 1 time unit after each rising edge; cyc counts edges since the last reset edge.
  int cyc = 0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, first_rise_cyc = 0;
  int last_rise_cyc = 0, last_fall_cyc = 0, rise_cnt = 0;
  int hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;
  int drdy_cnt = 0, drdy_cyc = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst) cyc = 0; else cyc = cyc + 1;
    if (prev_cs && !cs) begin
      cs_fall_cyc = cyc; rise_cnt = 0;
      hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
    end
    if (!prev_cs && cs) cs_rise_cyc = cyc;
    if (!prev_sclk && sclk) begin
      rise_cnt++;
      if (rise_cnt == 1) first_rise_cyc = cyc;
      else begin
        if (cyc - last_fall_cyc < lo_min) lo_min = cyc - last_fall_cyc;
        if (cyc - last_fall_cyc > lo_max) lo_max = cyc - last_fall_cyc;
      end
      last_rise_cyc = cyc;
    end
    if (prev_sclk && !sclk) begin
      if (cyc - last_rise_cyc < hi_min) hi_min = cyc - last_rise_cyc;
      if (cyc - last_rise_cyc > hi_max) hi_max = cyc - last_rise_cyc;
      last_fall_cyc = cyc;
    end
    if (drdy) begin drdy_cnt++; drdy_cyc = cyc; end
    prev_cs = cs;
    prev_sclk = sclk;
  end

  // Reference model: what a consumer should see after a frame.
  logic [11:0] m_data = '0;
  logic        m_open = 1'b0;
  logic        m_err  = 1'b0;

  task automatic model_frame(input int f);
    bit bad;
    bad = 1'b0;
`ifdef MAX6675_FRAME_CHECK_EN
    bad = (f >= 32768) || ((f / 2) % 2 == 1);
`endif
    m_err = bad;
    if (!bad) begin
      m_data = 12'((f / 8) % 4096);
      m_open = ((f / 4) % 2) == 1;
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_open = 1'b0; m_err = 1'b0;
  endtask

  task automatic wait_drdy(input int d0, input int limit, input string tag);
    int n;
    n = 0;
    while (drdy_cnt == d0 && n < limit) begin @(negedge clk); n++; end
    check({tag, "_drdy_seen"}, drdy_cnt - d0, 1);
  endtask

  task automatic check_frame(input string tag, input logic [11:0] ed, input logic eo, input logic ee);
    check({tag, "_data"}, data, ed);
    check({tag, "_open_tc"}, open_tc, eo);
    check({tag, "_frame_err"}, frame_err, ee);
    check({tag, "_len"}, drdy_cyc - cs_fall_cyc, FRAME_LEN);
    check({tag, "_pulses"}, rise_cnt, 16);
    @(negedge clk);
    check({tag, "_drdy_1cyc"}, drdy, 1'b0);
  endtask

  task automatic run_frame(input logic [15:0] f, input logic [11:0] ed, input logic eo,
                           input logic ee, input string tag);
    int n, d0;
    frame = f;
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    d0 = drdy_cnt;
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    wait_drdy(d0, 300, tag);
    check_frame(tag, ed, eo, ee);
  endtask

  typedef struct {
    logic [15:0] frame;
    logic [11:0] data;
    logic        open_tc;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, d0;
    vecs[0] = '{16'h0004, 12'h000, 1'b1, 1'b0};
    vecs[1] = '{16'h0C80, 12'h190, 1'b0, 1'b0};
    vecs[2] = '{16'h1F40, 12'h3E8, 1'b0, 1'b0};
`ifdef MAX6675_FRAME_CHECK_EN
    vecs[3] = '{16'hFFFF, 12'h3E8, 1'b0, 1'b1};
    vecs[4] = '{16'h7FF8, 12'hFFF, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 12'hFFF, 1'b0, 1'b1};
    vecs[6] = '{16'h0002, 12'hFFF, 1'b0, 1'b1};
`else
    vecs[3] = '{16'hFFFF, 12'hFFF, 1'b1, 1'b0};
    vecs[4] = '{16'h7FF8, 12'hFFF, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 12'h000, 1'b0, 1'b0};
    vecs[6] = '{16'h0002, 12'h000, 1'b0, 1'b0};
`endif

    // Reset values and the first timer-driven frame.
    frame = 16'h1F40;
    repeat (3) @(negedge clk);
    check("rst_cs", cs, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_data", data, 12'h000);
    check("rst_flags", {open_tc, drdy, busy, frame_err}, 4'b0000);
    rst = 1'b0;
    d0 = drdy_cnt;
    wait_drdy(d0, SP + 200, "a");
    check("a_cs_fall_cyc", cs_fall_cyc, SP);
    check("a_cs_to_first_rise", first_rise_cyc - cs_fall_cyc, CSU + D);
    check("a_last_fall_to_cs_rise", cs_rise_cyc - last_fall_cyc, CSU);
    check("a_hi_phase", {hi_min[15:0], hi_max[15:0]}, {16'(D), 16'(D)});
    check("a_lo_phase", {lo_min[15:0], lo_max[15:0]}, {16'(D), 16'(D)});
    check_frame("a", 12'h3E8, 1'b0, 1'b0);
    check("a_busy_after", busy, 1'b0);

    // trig at cycle 50, a second trig mid-SHIFT is dropped, timer frame still at SP.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    model_reset();
    n = 0;
    while (cyc != 50 && n < 100) begin @(negedge clk); n++; end
    check("b_reach_50", cyc, 50);
    d0 = drdy_cnt;
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    n = 0;
    while (rise_cnt < 3 && n < 100) begin @(negedge clk); n++; end
    check("b_in_shift", busy, 1'b1);
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    n = 0;
    while (cyc != SP - 1 && n < 300) begin @(negedge clk); n++; end
    check("b_one_drdy", drdy_cnt - d0, 1);
    check("b_trig_cs_fall", cs_fall_cyc, 51);
    @(negedge clk);
    check("b_timer_cs_fall", cs_fall_cyc, SP);
    wait_drdy(d0 + 1, 200, "b");
    model_frame(16'h1F40);
    check_frame("b", m_data, m_open, m_err);

    // Table vectors.
    for (int i = 0; i < 7; i++) begin
      model_frame(int'(vecs[i].frame));
      run_frame(vecs[i].frame, vecs[i].data, vecs[i].open_tc, vecs[i].err, $sformatf("vec%0d", i));
    end

    // Random frames against the model.
    for (int i = 0; i < 16; i++) begin
      logic [15:0] f;
      f = 16'($urandom_range(0, 65535));
      model_frame(int'(f));
      run_frame(f, m_data, m_open, m_err, $sformatf("rand%0d", i));
    end

    // Reset after the 8th sclk rise discards the frame and restarts the timer.
    frame = 16'h5555;
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    d0 = drdy_cnt;
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    n = 0;
    while (rise_cnt < 8 && n < 200) begin @(negedge clk); n++; end
    check("e_reach_rise8", rise_cnt, 8);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    model_reset();
    check("e_cs", cs, 1'b1);
    check("e_sclk", sclk, 1'b0);
    check("e_data", data, 12'h000);
    check("e_flags", {open_tc, drdy, busy, frame_err}, 4'b0000);
    frame = 16'h0C80;
    n = 0;
    while (cs && n < SP + 50) begin @(negedge clk); n++; end
    check("e_no_partial_drdy", drdy_cnt - d0, 0);
    check("e_restart_cs_fall", cs_fall_cyc, SP);
    wait_drdy(d0, 200, "e");
    model_frame(16'h0C80);
    check_frame("e", m_data, m_open, m_err);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
